// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op encodings, FSM states and helpers for muldiv_unit
//
// Purpose: common definitions imported by muldiv_unit and its sub-module.
//   OP_* constants equal the RV32M/RV64M funct3 encoding.
//   state_t is the three-state sequencer (IDLE/BUSY/FIN).
//   is_signed_op / is_signed_b tell whether rs1 / rs2 are read as signed.

package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIN  = 2'd2
  } state_t;

  // rs1 is signed for every op except the fully unsigned ones.
  // MUL is treated as signed; its low half is identical either way.
  function automatic logic is_signed_op(input logic [2:0] f_op);
    return f_op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  // rs2 is unsigned for MULHSU in addition to the unsigned ops.
  function automatic logic is_signed_b(input logic [2:0] f_op);
    return f_op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

  // Divide-class ops (DIV/DIVU/REM/REMU) all have funct3[2] set.
  function automatic logic is_div_op(input logic [2:0] f_op);
    return f_op[2];
  endfunction

  // Among divide-class ops, funct3[1] selects the remainder.
  function automatic logic is_rem_op(input logic [2:0] f_op);
    return f_op[1];
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// rtl/muldiv_sign_fix.sv - conditional two's-complement negate
//
// Purpose: produces the magnitude of a signed operand on the way in and
// re-applies the sign to a product, quotient or remainder on the way out.
// Ports:
//   i_val  [W-1:0]  value to condition
//   i_neg           1 = return -i_val (mod 2^W), 0 = pass through
//   o_val  [W-1:0]  conditioned value

module muldiv_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_val,
  input  logic         i_neg,
  output logic [W-1:0] o_val
);

  logic [W-1:0] w_one;
  assign w_one = {{(W-1){1'b0}}, 1'b1};

  // The most negative value maps onto itself, which as an unsigned
  // magnitude is exactly 2^(W-1), so no extra bit is needed.
  assign o_val = i_neg ? (~i_val + w_one) : i_val;

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M/RV64M multiply/divide execution unit
//
// Purpose: runs MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU on unsigned
// magnitudes, one radix-2 step per cycle (shift-add multiply, restoring
// divide), then re-applies the sign. Divide-by-zero and signed overflow
// skip the iteration and finish one cycle after acceptance.
// Optional build macro: MULDIV_FAST_MUL_EN - multiplies use a single-cycle
// combinational multiplier and always take the short path.
// Parameters: XLEN (32 or 64), TAG_W (destination tag width).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           request, accepted only while ready=1
//   op [2:0]        funct3 of the instruction
//   a, b [XLEN-1:0] rs1, rs2 values (captured at acceptance)
//   tag_in          rd of the instruction
//   ready           unit idle, can accept start
//   done            one-cycle pulse: result and tag_out valid
//   result          op result, held until the next completion
//   tag_out         tag captured at acceptance

module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  input  logic [TAG_W-1:0] tag_in,
  output logic             ready,
  output logic             done,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] tag_out
);

  localparam int CNT_W = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [2:0]         r_op;
  logic [XLEN-1:0]    r_a;
  logic [XLEN-1:0]    r_b;
  logic [XLEN-1:0]    r_m;       // multiplicand (mul) or divisor (div) magnitude
  logic [2*XLEN-1:0]  r_acc;     // mul: {partial hi, multiplier}; div: {rem, quo}
  logic [XLEN-1:0]    r_result;
  logic [TAG_W-1:0]   r_tag;
  logic               r_done;

  logic               w_ready;
  logic               w_take_fast;

  // Fast-path ops: divide by zero and signed MIN/-1 overflow.
  function automatic logic special_case(input logic [2:0]      f_op,
                                        input logic [XLEN-1:0] f_a,
                                        input logic [XLEN-1:0] f_b);
    return is_div_op(f_op) &&
           ((f_b == '0) ||
            (is_signed_op(f_op) && (f_a == MIN_NEG) && (f_b == '1)));
  endfunction

`ifdef MULDIV_FAST_MUL_EN
  assign w_take_fast = special_case(op, a, b) || !is_div_op(op);
`else
  assign w_take_fast = special_case(op, a, b);
`endif

  // ---------------------------------------------------------------------
  // Input conditioning: magnitudes of the live operands at acceptance
  // ---------------------------------------------------------------------
  logic            w_in_sa;
  logic            w_in_sb;
  logic [XLEN-1:0] w_mag_a;
  logic [XLEN-1:0] w_mag_b;

  assign w_in_sa = is_signed_op(op) & a[XLEN-1];
  assign w_in_sb = is_signed_b(op)  & b[XLEN-1];

  muldiv_sign_fix #(.W(XLEN)) u_mag_a (
    .i_val (a),
    .i_neg (w_in_sa),
    .o_val (w_mag_a)
  );

  muldiv_sign_fix #(.W(XLEN)) u_mag_b (
    .i_val (b),
    .i_neg (w_in_sb),
    .o_val (w_mag_b)
  );

  // ---------------------------------------------------------------------
  // One radix-2 step
  // ---------------------------------------------------------------------
  logic [XLEN-1:0]   w_acc_hi;
  logic [XLEN-1:0]   w_acc_lo;
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_next;
  logic [XLEN:0]     w_div_shift;
  logic              w_div_ge;
  logic [XLEN-1:0]   w_div_sub;
  logic [2*XLEN-1:0] w_div_next;

  assign w_acc_hi = r_acc[2*XLEN-1:XLEN];
  assign w_acc_lo = r_acc[XLEN-1:0];

  // Shift-add: add the multiplicand when the multiplier LSB is set, then
  // shift the whole accumulator right, carry included.
  assign w_mul_sum  = {1'b0, w_acc_hi} + (w_acc_lo[0] ? {1'b0, r_m} : {(XLEN+1){1'b0}});
  assign w_mul_next = {w_mul_sum, w_acc_lo[XLEN-1:1]};

  // Restoring divide: shift the next dividend bit into the remainder and
  // subtract the divisor when it fits. The partial remainder is always
  // below the divisor, so the difference fits in XLEN bits.
  assign w_div_shift = {w_acc_hi, w_acc_lo[XLEN-1]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_m});
  assign w_div_sub   = w_div_shift[XLEN-1:0] - r_m;
  assign w_div_next  = {(w_div_ge ? w_div_sub : w_div_shift[XLEN-1:0]),
                        w_acc_lo[XLEN-2:0], w_div_ge};

  // ---------------------------------------------------------------------
  // Output correction (evaluated in FIN from captured operands)
  // ---------------------------------------------------------------------
  logic              w_sa;
  logic              w_sb;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_fin_result;

  assign w_sa = is_signed_op(r_op) & r_a[XLEN-1];
  assign w_sb = is_signed_b(r_op)  & r_b[XLEN-1];

`ifdef MULDIV_FAST_MUL_EN
  // Operands as (XLEN+1)-bit signed values, sign-extended to 2*XLEN; the
  // low 2*XLEN bits of the product are all any multiply op needs.
  logic [2*XLEN-1:0] w_fa;
  logic [2*XLEN-1:0] w_fb;

  assign w_fa   = {{XLEN{w_sa}}, r_a};
  assign w_fb   = {{XLEN{w_sb}}, r_b};
  assign w_prod = w_fa * w_fb;
`else
  muldiv_sign_fix #(.W(2*XLEN)) u_fix_prod (
    .i_val (r_acc),
    .i_neg (w_sa ^ w_sb),
    .o_val (w_prod)
  );
`endif

  muldiv_sign_fix #(.W(XLEN)) u_fix_quo (
    .i_val (w_acc_lo),
    .i_neg (w_sa ^ w_sb),
    .o_val (w_quo)
  );

  // Remainder takes the sign of the dividend.
  muldiv_sign_fix #(.W(XLEN)) u_fix_rem (
    .i_val (w_acc_hi),
    .i_neg (w_sa),
    .o_val (w_rem)
  );

  always_comb begin
    w_fin_result = '0;
    if (special_case(r_op, r_a, r_b)) begin
      if (r_b == '0) begin
        w_fin_result = is_rem_op(r_op) ? r_a : '1;
      end else begin
        // MIN / -1: quotient wraps to MIN, remainder is zero.
        w_fin_result = is_rem_op(r_op) ? '0 : r_a;
      end
    end else begin
      case (r_op)
        OP_MUL:                       w_fin_result = w_prod[XLEN-1:0];
        OP_MULH, OP_MULHSU, OP_MULHU: w_fin_result = w_prod[2*XLEN-1:XLEN];
        OP_DIV, OP_DIVU:              w_fin_result = w_quo;
        default:                      w_fin_result = w_rem;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (start) begin
          w_next = w_take_fast ? FIN : BUSY;
        end
      end
      BUSY: begin
        if (r_cnt == CNT_W'(1)) begin
          w_next = FIN;
        end
      end
      FIN: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_m      <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_tag    <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_op  <= op;
            r_a   <= a;
            r_b   <= b;
            r_tag <= tag_in;
            r_m   <= is_div_op(op) ? w_mag_b : w_mag_a;
            r_acc <= {{XLEN{1'b0}}, (is_div_op(op) ? w_mag_a : w_mag_b)};
            r_cnt <= w_take_fast ? '0 : CNT_W'(XLEN);
          end
        end
        BUSY: begin
          r_acc <= is_div_op(r_op) ? w_div_next : w_mul_next;
          r_cnt <= r_cnt - CNT_W'(1);
        end
        FIN: begin
          r_result <= w_fin_result;
          r_done   <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign ready   = w_ready;
  assign done    = r_done;
  assign result  = r_result;
  assign tag_out = r_tag;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit

module tb_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
`else
  localparam bit FAST_MUL = 1'b0;
`endif

  localparam int LIMIT = 2 * XLEN + 10;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [2:0]       op;
  logic [XLEN-1:0]  a;
  logic [XLEN-1:0]  b;
  logic [TAG_W-1:0] tag_in;
  logic             ready;
  logic             done;
  logic [XLEN-1:0]  result;
  logic [TAG_W-1:0] tag_out;

  int n_checks = 0;
  int n_errors = 0;

  logic [XLEN-1:0] all1;
  logic [XLEN-1:0] min_neg;
  logic [XLEN-1:0] one;

  muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .tag_in  (tag_in),
    .ready   (ready),
    .done    (done),
    .result  (result),
    .tag_out (tag_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] sx(input longint v);
    return XLEN'(v);
  endfunction

  // Reference: exact arithmetic on wide integers, then the RISC-V rules.
  function automatic logic [XLEN-1:0] model(input logic [2:0] f_op,
                                            input logic [XLEN-1:0] f_a,
                                            input logic [XLEN-1:0] f_b);
    logic signed [131:0] sa, sb, ua, ub, p;
    logic [XLEN-1:0] mn;
    mn = {1'b1, {(XLEN-1){1'b0}}};
    sa = {{(132-XLEN){f_a[XLEN-1]}}, f_a};
    sb = {{(132-XLEN){f_b[XLEN-1]}}, f_b};
    ua = {{(132-XLEN){1'b0}}, f_a};
    ub = {{(132-XLEN){1'b0}}, f_b};
    p  = '0;
    model = '0;
    case (f_op)
      OP_MUL:    begin p = sa * sb; model = p[XLEN-1:0]; end
      OP_MULH:   begin p = sa * sb; model = p[2*XLEN-1:XLEN]; end
      OP_MULHSU: begin p = sa * ub; model = p[2*XLEN-1:XLEN]; end
      OP_MULHU:  begin p = ua * ub; model = p[2*XLEN-1:XLEN]; end
      OP_DIV: begin
        if (f_b == '0) model = '1;
        else if (f_a == mn && f_b == '1) model = f_a;
        else begin p = sa / sb; model = p[XLEN-1:0]; end
      end
      OP_DIVU: begin
        if (f_b == '0) model = '1;
        else begin p = ua / ub; model = p[XLEN-1:0]; end
      end
      OP_REM: begin
        if (f_b == '0) model = f_a;
        else if (f_a == mn && f_b == '1) model = '0;
        else begin p = sa % sb; model = p[XLEN-1:0]; end
      end
      default: begin
        if (f_b == '0) model = f_a;
        else begin p = ua % ub; model = p[XLEN-1:0]; end
      end
    endcase
  endfunction

  function automatic int lat_exp(input logic [2:0] f_op,
                                 input logic [XLEN-1:0] f_a,
                                 input logic [XLEN-1:0] f_b);
    logic [XLEN-1:0] mn;
    mn = {1'b1, {(XLEN-1){1'b0}}};
    if (f_op[2] && (f_b == '0 || ((f_op == OP_DIV || f_op == OP_REM) && f_a == mn && f_b == '1)))
      return 1;
    if (!f_op[2] && FAST_MUL)
      return 1;
    return XLEN + 1;
  endfunction

  function automatic logic [XLEN-1:0] rand_val();
    logic [63:0] w;
    w = {$urandom, $urandom};
    case ($urandom_range(0, 9))
      0: return '0;
      1: return '1;
      2: return {1'b1, {(XLEN-1){1'b0}}};
      3: return XLEN'($urandom_range(0, 15));
      4: return sx(-longint'($urandom_range(1, 15)));
      5: return {1'b0, {(XLEN-1){1'b1}}};
      default: return XLEN'(w);
    endcase
  endfunction

  // Counts edges from the acceptance edge until done is seen; -1 on timeout.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done && n < LIMIT);
    if (!done) n = -1;
  endtask

  task automatic run_op(input logic [2:0] f_op, input logic [XLEN-1:0] f_a,
                        input logic [XLEN-1:0] f_b, input logic [TAG_W-1:0] f_tag,
                        output logic [XLEN-1:0] got, output int lat,
                        output logic [TAG_W-1:0] got_tag);
    @(negedge clk);
    start = 1'b1; op = f_op; a = f_a; b = f_b; tag_in = f_tag;
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble inputs: captured operands must not follow them.
    op = 3'($urandom); a = rand_val(); b = rand_val(); tag_in = TAG_W'($urandom);
    check("ready_low_after_accept", 64'(ready), 64'(0));
    wait_done(lat);
    got = result;
    got_tag = tag_out;
  endtask

  task automatic directed(input string tag, input logic [2:0] f_op,
                          input logic [XLEN-1:0] f_a, input logic [XLEN-1:0] f_b,
                          input logic [XLEN-1:0] exp);
    logic [XLEN-1:0]  got;
    logic [TAG_W-1:0] gt;
    logic [TAG_W-1:0] t;
    int lat;
    t = TAG_W'($urandom);
    run_op(f_op, f_a, f_b, t, got, lat, gt);
    check({tag, "_result"}, 64'(got), 64'(exp));
    check({tag, "_latency"}, 64'(lat), 64'(lat_exp(f_op, f_a, f_b)));
    check({tag, "_tag"}, 64'(gt), 64'(t));
  endtask

  initial begin
    logic [XLEN-1:0]  got;
    logic [XLEN-1:0]  keep_res;
    logic [TAG_W-1:0] gt;
    logic [TAG_W-1:0] keep_tag;
    logic [2:0]       rop;
    logic [XLEN-1:0]  ra;
    logic [XLEN-1:0]  rb;
    logic [TAG_W-1:0] rt;
    int lat;
    int n_done;

    all1    = '1;
    min_neg = {1'b1, {(XLEN-1){1'b0}}};
    one     = {{(XLEN-1){1'b0}}, 1'b1};
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; tag_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready",  64'(ready),   64'(1));
    check("reset_done",   64'(done),    64'(0));
    check("reset_result", 64'(result),  64'(0));
    check("reset_tag",    64'(tag_out), 64'(0));
    rst = 1'b0;

    directed("mul_7_m3",       OP_MUL,    sx(7),   sx(-3), sx(-21));
    directed("mulh_min_min",   OP_MULH,   min_neg, min_neg, one << (XLEN - 2));
    directed("mulhsu_m1_all1", OP_MULHSU, all1,    all1,    all1);
    directed("mulhu_all1",     OP_MULHU,  all1,    all1,    all1 - one);
    directed("div_m7_2",       OP_DIV,    sx(-7),  sx(2),   sx(-3));
    directed("rem_m7_2",       OP_REM,    sx(-7),  sx(2),   sx(-1));
    directed("divu_100_7",     OP_DIVU,   sx(100), sx(7),   sx(14));
    directed("remu_100_7",     OP_REMU,   sx(100), sx(7),   sx(2));
    directed("div_by_zero",    OP_DIV,    sx(5),   '0,      all1);
    directed("rem_by_zero",    OP_REM,    sx(5),   '0,      sx(5));
    directed("divu_by_zero",   OP_DIVU,   sx(5),   '0,      all1);
    directed("remu_by_zero",   OP_REMU,   sx(5),   '0,      sx(5));
    directed("div_overflow",   OP_DIV,    min_neg, all1,    min_neg);
    directed("rem_overflow",   OP_REM,    min_neg, all1,    '0);

    // start while busy is ignored
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; a = sx(100); b = sx(7); tag_in = TAG_W'(3);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = OP_MUL; a = sx(5); b = sx(5); tag_in = TAG_W'(9);
    @(negedge clk);
    start = 1'b0;
    n_done = 0; keep_res = '0; keep_tag = '0;
    for (int i = 0; i < XLEN + 8; i++) begin
      @(posedge clk); #1;
      if (done) begin
        n_done++;
        keep_res = result;
        keep_tag = tag_out;
      end
    end
    check("busy_start_done_count", 64'(n_done), 64'(1));
    check("busy_start_result",     64'(keep_res), 64'(14));
    check("busy_start_tag",        64'(keep_tag), 64'(3));

    // back-to-back: start during the done cycle
    run_op(OP_DIVU, sx(100), sx(7), TAG_W'(5), got, lat, gt);
    check("b2b_first_result", 64'(got), 64'(14));
    start = 1'b1; op = OP_REMU; a = sx(100); b = sx(7); tag_in = TAG_W'(6);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat);
    check("b2b_second_latency", 64'(lat), 64'(XLEN + 1));
    check("b2b_second_result",  64'(result), 64'(2));
    check("b2b_second_tag",     64'(tag_out), 64'(6));

    // reset mid-operation
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; a = all1; b = sx(3); tag_in = TAG_W'(7);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_ready",  64'(ready),   64'(1));
    check("midrst_done",   64'(done),    64'(0));
    check("midrst_result", 64'(result),  64'(0));
    check("midrst_tag",    64'(tag_out), 64'(0));
    n_done = 0;
    for (int i = 0; i < XLEN + 4; i++) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    check("midrst_no_done", 64'(n_done), 64'(0));

    // randomized against the reference model
    for (int i = 0; i < 150; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = rand_val();
      rb  = rand_val();
      rt  = TAG_W'($urandom);
      run_op(rop, ra, rb, rt, got, lat, gt);
      check($sformatf("rand%0d_op%0d_a%0h_b%0h_result", i, rop, ra, rb), 64'(got), 64'(model(rop, ra, rb)));
      check($sformatf("rand%0d_op%0d_latency", i, rop), 64'(lat), 64'(lat_exp(rop, ra, rb)));
      check($sformatf("rand%0d_tag", i), 64'(gt), 64'(rt));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M/RV64M multiply/divide execution unit for the next-generation core.
- Executes all eight M-extension ops (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) over multiple cycles.
- Uses a start/ready/done handshake so the core can stall its PC and register writeback while an op is in flight.
- Sits beside the ALU; the core routes OP-class instructions with funct7=0000001 here. The result and the tagged rd return to the writeback mux.

Parameters:
- XLEN, 32: operand and result width; legal values 32 or 64.
- TAG_W, 5: width of the destination-register tag carried through the unit.

Ports:
- clk  input  1  clock.
- rst  input  1  reset: synchronous, active-high.
- start  input  1  request; accepted only when ready=1.
- op  input  3  funct3 of the instruction (000 MUL … 111 REMU).
- a  input  XLEN  rs1 value.
- b  input  XLEN  rs2 value.
- tag_in  input  TAG_W  rd of the instruction.
- ready  output  1  unit idle; can accept start.
- done  output  1  one-cycle pulse: result and tag_out are valid.
- result  output  XLEN  op result; held stable until the next accepted start.
- tag_out  output  TAG_W  tag_in captured at acceptance.

Behaviour:
- Reset values: ready=1, done=0, result=0, tag_out=0, state=IDLE, iteration counter=0.
- States:
  - IDLE: ready=1. If start=1, latch op, a, b and tag_in.
    - Special case detected: go to FIN.
    - Otherwise: go to BUSY with counter=XLEN.
  - BUSY: ready=0. Perform one radix-2 iteration per cycle and decrement the counter. Go to FIN when the counter reaches 1 and that iteration completes.
  - FIN: apply sign correction, register result, assert done for one cycle, then go to IDLE. ready=0 in FIN; ready=1 again on the cycle done is high.
- Latency, measured from the edge that samples start (edge 0):
  - Normal op: done is high between edge XLEN+1 and edge XLEN+2.
  - Special case: done is high between edge 1 and edge 2.
- Operand handling:
  - Signed ops take magnitudes; the sign of each operand is its MSB.
  - MULHSU treats a as signed and b as unsigned.
  - Core is unsigned: shift-add for multiply into a 2*XLEN accumulator; restoring shift-subtract for divide.
- Result selection:
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
  - Product sign = sign(a) XOR sign(b), applied only where the op is signed.
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
- Special cases (fast path, no iteration):
  - Divide by zero: DIV/DIVU return all ones; REM/REMU return a.
  - Signed overflow (a = most negative, b = -1): DIV returns a; REM returns 0.
- Boundary rules:
  - start while ready=0 is ignored; no queuing and no corruption of the op in flight.
  - start high in the same cycle done is high is accepted, giving back-to-back ops.
  - rst mid-operation returns to IDLE immediately and clears done and result; the partial op is discarded.
  - Operands are captured at acceptance; later changes to a/b/op have no effect.
  - Arithmetic wraps modulo 2^XLEN; no exceptions are raised.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined:
  - Multiply ops use a combinational XLEN+1 × XLEN+1 signed multiplier on sign-extended operands.
  - They always take the fast path: done high between edge 1 and edge 2.
  - Divide behaviour is unchanged.
- Undefined: multiply uses the iterative shift-add path at the full XLEN+1 latency.
- Results are bit-identical either way.

Decomposition:
- Shared package muldiv_pkg holds:
  - op encoding constants OP_MUL … OP_REMU (3-bit, equal to funct3);
  - state enum IDLE/BUSY/FIN;
  - helper function is_signed_op.
- One natural sub-module, muldiv_sign_fix: combinational magnitude/negate logic shared by input conditioning and output correction.

Test Plan (XLEN=32 unless noted):
- MUL a=7, b=-3 → result 0xFFFFFFEB; done exactly at edge 33; tag_out equals tag_in.
- MULH a=0x80000000, b=0x80000000 → 0x40000000. MULHSU a=-1, b=0xFFFFFFFF → 0xFFFFFFFF. MULHU a=b=0xFFFFFFFF → 0xFFFFFFFE.
- DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIV a=5, b=0 → 0xFFFFFFFF and REM a=5, b=0 → 5, both with done at edge 1. DIV 0x80000000/-1 → 0x80000000 and REM of the same operands → 0, both at edge 1.
- Second start pulsed while busy is ignored (one done, first result). start in the done cycle gives a second done exactly XLEN+1 cycles later. rst at iteration 10 gives ready=1, done=0, result=0 next cycle.
- Repeat the checks with XLEN=64 and with MULDIV_FAST_MUL_EN defined: identical results; MUL latency is 1.
